// File: rtl/instr_queue.sv
// Instruction FIFO with combinational RV32I field/immediate decode of the head entry; one-cycle push-to-output latency.
// in_ready drops when full (no push-through on a full pop); optional INSTR_QUEUE_BYPASS_EN adds a zero-latency empty-queue bypass.
module instr_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [6:0]               opcode,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [31:0]              i_imm,
  output logic [31:0]              s_imm,
  output logic [31:0]              b_imm,
  output logic [31:0]              u_imm,
  output logic [31:0]              j_imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [31:0]         r_instr [DEPTH];
  logic [PC_WIDTH-1:0] r_pc    [DEPTH];
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [AW:0]         r_count;

  logic                w_empty;
  logic                w_push;
  logic                w_wr;
  logic                w_rd;
  logic [31:0]         w_d;
  logic [PC_WIDTH-1:0] w_pc;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != LP_DEPTH);
  assign w_push   = in_valid && in_ready && !flush;
  assign count    = r_count;

`ifdef INSTR_QUEUE_BYPASS_EN
  // An empty queue presents the producer's word directly; it is stored only if not taken this cycle.
  assign out_valid = w_empty ? in_valid : 1'b1;
  assign w_d       = w_empty ? in_instr : r_instr[r_head];
  assign w_pc      = w_empty ? in_pc    : r_pc[r_head];
  assign w_wr      = w_push && !(w_empty && out_ready);
  assign w_rd      = !w_empty && out_ready && !flush;
`else
  assign out_valid = !w_empty;
  assign w_d       = r_instr[r_head];
  assign w_pc      = r_pc[r_head];
  assign w_wr      = w_push;
  assign w_rd      = out_valid && out_ready && !flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + AW'(1);
      if (w_rd) r_head <= r_head + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot contents survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_instr[k] <= '0;
        r_pc[k]    <= '0;
      end
    end else if (w_wr) begin
      r_instr[r_tail] <= in_instr;
      r_pc[r_tail]    <= in_pc;
    end
  end

  assign out_pc = w_pc;
  assign opcode = w_d[6:0];
  assign rd     = w_d[11:7];
  assign funct3 = w_d[14:12];
  assign rs1    = w_d[19:15];
  assign rs2    = w_d[24:20];
  assign funct7 = w_d[31:25];

  assign i_imm = {{20{w_d[31]}}, w_d[31:20]};
  assign s_imm = {{20{w_d[31]}}, w_d[31:25], w_d[11:7]};
  assign b_imm = {{19{w_d[31]}}, w_d[31], w_d[7], w_d[30:25], w_d[11:8], 1'b0};
  assign u_imm = {w_d[31:12], 12'h000};
  assign j_imm = {{11{w_d[31]}}, w_d[31], w_d[19:12], w_d[20], w_d[30:21], 1'b0};

endmodule

// File: tb/tb_instr_queue.sv
// Randomized + directed bench for instr_queue with a queue-based reference model and a decoupled pop monitor.
module tb_instr_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [2:0]  funct3;
  logic [6:0]  funct7, opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [2:0]  count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  ent_t sb[$];

  instr_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediates rebuilt with signed shifts and masks rather than bit concatenation.
  function automatic logic [31:0] ref_imm(input logic [31:0] d, input int kind);
    logic signed [31:0] sd, top, t;
    logic [31:0] r;
    sd  = d;
    top = sd >>> 31;
    r   = '0;
    case (kind)
      0: begin t = sd >>> 20; r = t; end
      1: begin t = sd >>> 25; r = (t << 5) | ((d >> 7) & 32'd31); end
      2: r = (top << 12) | (((d >> 7) & 32'd1) << 11) | (((d >> 25) & 32'd63) << 5) | (((d >> 8) & 32'd15) << 1);
      3: r = d & 32'hFFFF_F000;
      default: r = (top << 20) | (((d >> 12) & 32'd255) << 12) | (((d >> 20) & 32'd1) << 11) | (((d >> 21) & 32'd1023) << 1);
    endcase
    return r;
  endfunction

  // Monitor: occupancy every cycle, full field compare on each consumed entry.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("pop_on_empty", 32'(1), 32'(0));
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("opcode", 32'(opcode), e.instr & 32'h7F);
          chk("rd", 32'(rd), (e.instr >> 7) & 32'd31);
          chk("funct3", 32'(funct3), (e.instr >> 12) & 32'd7);
          chk("rs1", 32'(rs1), (e.instr >> 15) & 32'd31);
          chk("rs2", 32'(rs2), (e.instr >> 20) & 32'd31);
          chk("funct7", 32'(funct7), e.instr >> 25);
          chk("i_imm", i_imm, ref_imm(e.instr, 0));
          chk("s_imm", s_imm, ref_imm(e.instr, 1));
          chk("b_imm", b_imm, ref_imm(e.instr, 2));
          chk("u_imm", u_imm, ref_imm(e.instr, 3));
          chk("j_imm", j_imm, ref_imm(e.instr, 4));
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    bit mp, mo;
    @(posedge clk); #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    @(negedge clk); #1;
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      mp = v && (m_cnt < DEPTH);
      mo = rdy && (m_cnt > 0);
      if (mp) sb.push_back('{instr: ins, pc: pc});
      m_cnt = m_cnt + int'(mp) - int'(mo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_i_imm", i_imm, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    #22 rst_n = 1'b1;

    // addi x1,x0,5 at 0x100
    cyc(1, 32'h0050_0093, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_opcode", 32'(opcode), 32'h13);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rs1", 32'(rs1), 32'd0);
    chk("addi_funct3", 32'(funct3), 32'd0);
    chk("addi_i_imm", i_imm, 32'h5);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_count", 32'(count), 32'd1);
    cyc(0, 0, 0, 1, 0);

    cyc(1, 32'hFE00_0EE3, 32'h200, 0, 0);
    cyc(1, 32'hFFF0_0113, 32'h204, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("beq_b_imm", b_imm, 32'hFFFF_FFFC);
    chk("beq_opcode", 32'(opcode), 32'h63);
    chk("beq_rs1", 32'(rs1), 32'd0);
    chk("beq_rs2", 32'(rs2), 32'd0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("neg1_i_imm", i_imm, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 1, 0);

    // Fill to full, offer a fifth, then drain in order.
    for (int k = 0; k < 5; k++) cyc(1, $urandom, 32'(4 * k), 0, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("drained_count", 32'(count), 32'd0);

    // Steady push+pop at occupancy 2 across several wraps.
    cyc(1, $urandom, 32'h300, 0, 0);
    cyc(1, $urandom, 32'h304, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, $urandom, 32'h308 + 32'(4 * k), 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("steady_count", 32'(count), 32'd2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Flush with push and pop both requested.
    for (int k = 0; k < 3; k++) cyc(1, $urandom, 32'h400 + 32'(4 * k), 0, 0);
    cyc(1, $urandom, 32'h40C, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with two entries queued.
    cyc(1, $urandom, 32'h500, 0, 0);
    cyc(1, $urandom, 32'h504, 0, 0);
    @(posedge clk); #3;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    sb.delete();
    m_cnt = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(1, 32'h0050_0093, 32'h600, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_pc", out_pc, 32'h600);

    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom,
          1'($urandom_range(0, 2) != 0 ? (k % 200 < 100) : $urandom_range(0, 1)),
          1'($urandom_range(0, 31) == 0));
    end
    for (int k = 0; k < DEPTH + 1; k++) cyc(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction slots; power of two, 2..16.
REQ-002 Parameter PC_WIDTH, default 32, width of the per-entry PC tag.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous and active-low (asserted at 0).
REQ-005 Port flush  input  1  synchronous queue clear, e.g. on branch redirect.
REQ-006 Port in_valid  input  1  producer presents an instruction.
REQ-007 Port in_ready  output  1  queue can accept; equals (count < DEPTH).
REQ-008 Port in_instr  input  32  raw RV32I instruction word.
REQ-009 Port in_pc  input  PC_WIDTH  PC of in_instr.
REQ-010 Port out_valid  output  1  head entry valid.
REQ-011 Port out_ready  input  1  consumer takes the head entry.
REQ-012 Port out_pc  output  PC_WIDTH  PC of head entry.
REQ-013 Ports funct3 (3), funct7 (7), opcode (rv32i_opcode, 7), rs1/rs2/rd (5 each)  output  decoded head fields.
REQ-014 Ports i_imm, s_imm, b_imm, u_imm, j_imm  output  32 each  decoded head immediates.
REQ-015 Port count  output  $clog2(DEPTH)+1  number of occupied slots.

Function
REQ-016 Push occurs when in_valid && in_ready && !flush; entry written at the tail, tail pointer advances modulo DEPTH.
REQ-017 Pop occurs when out_valid && out_ready && !flush; head pointer advances modulo DEPTH.
REQ-018 Simultaneous push and pop leave count unchanged; both pointers advance.
REQ-019 in_ready is deasserted when full; no push-through on a full-queue pop in the same cycle.
REQ-020 out_valid equals (count != 0) in the default build.
REQ-021 Latency: a pushed entry is visible on the outputs the cycle after the push edge.
REQ-022 Decode is combinational from the head instruction word d: funct3=d[14:12], funct7=d[31:25], opcode=d[6:0], rs1=d[19:15], rs2=d[24:20], rd=d[11:7].
REQ-023 i_imm = sign-extended d[31:20]; s_imm = sign-extended {d[31:25],d[11:7]}; b_imm = sign-extended {d[31],d[7],d[30:25],d[11:8],0}; u_imm = {d[31:12],12'h000}; j_imm = sign-extended {d[31],d[19:12],d[20],d[30:21],0}.
REQ-024 When out_valid=0 the decoded outputs reflect the head slot contents; consumers ignore them.
REQ-025 flush has priority over push and pop: count, head and tail go to 0 next edge; slot contents untouched.
REQ-026 Pointer wrap-around is transparent: entry order is strictly FIFO across any number of wraps.

Reset
REQ-027 rst_n=0 immediately clears head, tail and count and all slot words/PCs to 0, independent of clk.
REQ-028 During and after reset: out_valid=0, in_ready=1, count=0, all decoded fields and out_pc 0.
REQ-029 Reset asserted mid-operation discards all entries; first push after release behaves as into an empty queue.

Configuration
REQ-030 Macro INSTR_QUEUE_BYPASS_EN: when defined, an empty queue forwards in_instr/in_pc combinationally to the outputs with out_valid=in_valid (zero latency); if out_ready is also 1 the entry is consumed and not stored; otherwise it is stored as in REQ-016.
REQ-031 Without INSTR_QUEUE_BYPASS_EN, no combinational path from in_* to out_*; latency per REQ-021.

Verification
REQ-032 After reset, push 0x00500093 at PC 0x100 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, funct3=0, i_imm=0x00000005, out_pc=0x100, count=1.
REQ-033 Push 0xFE000EE3 (beq x0,x0,-4) -> b_imm=0xFFFFFFFC, opcode=0x63, rs1=0, rs2=0; push 0xFFF00113 -> i_imm=0xFFFFFFFF.
REQ-034 DEPTH=4, out_ready=0, push 4 entries -> count=4, in_ready=0; 5th in_valid ignored; then drain -> entries in push order, PCs 0x0,0x4,0x8,0xC.
REQ-035 Continuous push+pop for 10 entries at count=2 -> count stays 2, order preserved across wrap.
REQ-036 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing pushed or popped.
REQ-037 count=2, rst_n pulled low between edges -> out_valid=0, count=0 immediately; with INSTR_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, in_instr=0x00500093 -> same-cycle out_valid=1, rd=1, count stays 0.
